// File: rtl/pin_mux_ctrl_if.sv
// rtl/pin_mux_ctrl_if.sv - SoC-side bundle for the header-bank pin multiplexer
// Carries GPIO, alternate-function, pad and interrupt signals between SoC and mux.
interface pin_mux_ctrl_if #(
  parameter int N_PINS = 19,
  parameter int SEL_W  = 2
);
  localparam int N_FUNC = 2 ** SEL_W;

  logic [N_PINS-1:0]              iPIO_OUT;
  logic [N_PINS-1:0]              iPIO_DIR;
  logic [N_PINS*SEL_W-1:0]        iMSEL;
  logic [(N_FUNC-1)*N_PINS-1:0]   iALT_OUT;
  logic [N_PINS-1:0]              iPIN_IN;
  logic [N_PINS-1:0]              iIRQ_RISE_EN;
  logic [N_PINS-1:0]              iIRQ_FALL_EN;
  logic [N_PINS-1:0]              iIRQ_CLR;
  logic [N_PINS-1:0]              oPIN_OUT;
  logic [N_PINS-1:0]              oPIN_OE;
  logic [N_PINS-1:0]              oPIO_IN;
  logic [N_PINS*SEL_W-1:0]        oMSEL_ACT;
  logic [N_PINS-1:0]              oIRQ_PEND;
  logic                           oIRQ;

  modport master (
    output iPIO_OUT, iPIO_DIR, iMSEL, iALT_OUT, iPIN_IN,
    output iIRQ_RISE_EN, iIRQ_FALL_EN, iIRQ_CLR,
    input  oPIN_OUT, oPIN_OE, oPIO_IN, oMSEL_ACT, oIRQ_PEND, oIRQ
  );

  modport slave (
    input  iPIO_OUT, iPIO_DIR, iMSEL, iALT_OUT, iPIN_IN,
    input  iIRQ_RISE_EN, iIRQ_FALL_EN, iIRQ_CLR,
    output oPIN_OUT, oPIN_OE, oPIO_IN, oMSEL_ACT, oIRQ_PEND, oIRQ
  );
endinterface

// File: rtl/pin_mux_ctrl.sv
// rtl/pin_mux_ctrl.sv - per-pin function mux with break-before-make and edge IRQs
// Each pin runs its own ACTIVE/BREAK FSM; pad outputs and oMSEL_ACT share one register stage.
module pin_mux_ctrl #(
  parameter int N_PINS      = 19,
  parameter int SEL_W       = 2,
  parameter int BBM_CYCLES  = 4,
  parameter int SYNC_STAGES = 2
) (
  input logic           iCLK,
  input logic           iRESET,
  pin_mux_ctrl_if.slave bus
);
  localparam int N_FUNC = 2 ** SEL_W;
  localparam logic [7:0] CNT_LOAD = (BBM_CYCLES > 0) ? 8'(BBM_CYCLES - 1) : 8'd0;

  typedef enum logic {ST_ACTIVE = 1'b0, ST_BREAK = 1'b1} pinState_t;

  logic [N_PINS-1:0]       oeNext;
  logic [N_PINS-1:0]       outNext;
  logic [N_PINS*SEL_W-1:0] selCur;
  logic [N_PINS-1:0]       pinOeQ;
  logic [N_PINS-1:0]       pinOutQ;
  logic [N_PINS*SEL_W-1:0] mselActQ;

  for (genvar gi = 0; gi < N_PINS; gi++) begin : gPin
    pinState_t        stateQ, stateD;
    logic [7:0]       cntQ, cntD;
    logic [SEL_W-1:0] tgtQ, tgtD;
    logic [SEL_W-1:0] curQ, curD;
    logic [SEL_W-1:0] req;
    logic             altBit;
    logic             oeD;
    logic             outD;

    assign req = bus.iMSEL[gi*SEL_W +: SEL_W];

    always_ff @(posedge iCLK) begin
      if (iRESET) begin
        stateQ <= ST_ACTIVE;
        cntQ   <= '0;
        tgtQ   <= '0;
        curQ   <= '0;
      end else begin
        stateQ <= stateD;
        cntQ   <= cntD;
        tgtQ   <= tgtD;
        curQ   <= curD;
      end
    end

    // Any request differing from the latched target restarts the window, so
    // the pad only ever leaves tri-state into the final requested function.
    always_comb begin
      stateD = stateQ;
      cntD   = cntQ;
      tgtD   = tgtQ;
      curD   = curQ;
      case (stateQ)
        ST_ACTIVE: begin
          if (req != curQ) begin
            if (BBM_CYCLES == 0) begin
              curD = req;
            end else begin
              tgtD   = req;
              cntD   = CNT_LOAD;
              stateD = ST_BREAK;
            end
          end
        end
        ST_BREAK: begin
          if (req != tgtQ) begin
            tgtD = req;
            cntD = CNT_LOAD;
          end else if (cntQ == 8'd0) begin
            curD   = tgtQ;
            stateD = ST_ACTIVE;
          end else begin
            cntD = cntQ - 8'd1;
          end
        end
        default: stateD = ST_ACTIVE;
      endcase
    end

    always_comb begin
      altBit = 1'b0;
      for (int k = 1; k < N_FUNC; k++) begin
        if (curQ == SEL_W'(k)) altBit = bus.iALT_OUT[(k-1)*N_PINS + gi];
      end
      oeD  = 1'b0;
      outD = 1'b0;
      if (stateQ == ST_ACTIVE) begin
        if (curQ == '0) begin
          oeD  = bus.iPIO_DIR[gi];
          outD = bus.iPIO_DIR[gi] & bus.iPIO_OUT[gi];
        end else begin
          oeD  = 1'b1;
          outD = altBit;
        end
      end
    end

    assign oeNext[gi]                  = oeD;
    assign outNext[gi]                 = outD;
    assign selCur[gi*SEL_W +: SEL_W]   = curQ;
  end

  // oMSEL_ACT is registered alongside the pad so it flips on the edge the new function drives.
  always_ff @(posedge iCLK) begin
    if (iRESET) begin
      pinOeQ   <= '0;
      pinOutQ  <= '0;
      mselActQ <= '0;
    end else begin
      pinOeQ   <= oeNext;
      pinOutQ  <= outNext;
      mselActQ <= selCur;
    end
  end

  logic [N_PINS-1:0] syncQ [SYNC_STAGES];
  logic [N_PINS-1:0] syncCur;
  logic [N_PINS-1:0] prevQ;
  logic [N_PINS-1:0] pendQ;
  logic [N_PINS-1:0] edgeSet;
  logic              irqQ;

  assign syncCur = syncQ[SYNC_STAGES-1];
  assign edgeSet = (~prevQ &  syncCur & bus.iIRQ_RISE_EN)
                 | ( prevQ & ~syncCur & bus.iIRQ_FALL_EN);

  always_ff @(posedge iCLK) begin
    if (iRESET) begin
      for (int s = 0; s < SYNC_STAGES; s++) syncQ[s] <= '0;
      prevQ <= '0;
      pendQ <= '0;
      irqQ  <= 1'b0;
    end else begin
      syncQ[0] <= bus.iPIN_IN;
      for (int s = 1; s < SYNC_STAGES; s++) syncQ[s] <= syncQ[s-1];
      prevQ <= syncCur;
      pendQ <= (pendQ & ~bus.iIRQ_CLR) | edgeSet;
      irqQ  <= |pendQ;
    end
  end

  assign bus.oPIN_OE   = pinOeQ;
  assign bus.oPIN_OUT  = pinOutQ;
  assign bus.oMSEL_ACT = mselActQ;
  assign bus.oPIO_IN   = syncCur;
  assign bus.oIRQ_PEND = pendQ;
  assign bus.oIRQ      = irqQ;
endmodule

// File: tb/tb_pin_mux_ctrl.sv
// tb/tb_pin_mux_ctrl.sv - scoreboard bench for the header-bank pin multiplexer
// Expectations are queued with a due cycle when stimulus is applied and checked at negedge.
module tb_pin_mux_ctrl;
  localparam int N_PINS = 19;
  localparam int SEL_W  = 2;
  localparam int BBM    = 4;
  localparam int SYNC   = 2;
  localparam int ALT_W  = (2 ** SEL_W - 1) * N_PINS;

  localparam int F_OE = 0, F_OUT = 1, F_MSEL = 2, F_PEND = 3, F_IRQ = 4, F_PIN = 5;
  localparam int V_OE = 6, V_OUT = 7, V_MSEL = 8, V_PEND = 9, V_PIN = 10;

  typedef struct {
    string       tag;
    int          field;
    int          pin;
    logic [63:0] exp;
    int          due;
  } sbEntry_t;

  logic     iCLK = 1'b0;
  logic     iRESET;
  int       cyc = 0;
  int       nChecks = 0;
  int       nBad = 0;
  sbEntry_t sbQ[$];

  pin_mux_ctrl_if #(.N_PINS(N_PINS), .SEL_W(SEL_W)) bus ();

  pin_mux_ctrl #(
    .N_PINS(N_PINS), .SEL_W(SEL_W), .BBM_CYCLES(BBM), .SYNC_STAGES(SYNC)
  ) dut (
    .iCLK(iCLK),
    .iRESET(iRESET),
    .bus(bus)
  );

  always #5 iCLK = ~iCLK;
  always @(posedge iCLK) cyc <= cyc + 1;

  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nChecks++;
    if (got !== exp) begin
      nBad++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [63:0] getField(input int field, input int pin);
    case (field)
      F_OE:    return 64'(bus.oPIN_OE[pin]);
      F_OUT:   return 64'(bus.oPIN_OUT[pin]);
      F_MSEL:  return 64'(bus.oMSEL_ACT[pin*SEL_W +: SEL_W]);
      F_PEND:  return 64'(bus.oIRQ_PEND[pin]);
      F_IRQ:   return 64'(bus.oIRQ);
      F_PIN:   return 64'(bus.oPIO_IN[pin]);
      V_OE:    return 64'(bus.oPIN_OE);
      V_OUT:   return 64'(bus.oPIN_OUT);
      V_MSEL:  return 64'(bus.oMSEL_ACT);
      V_PEND:  return 64'(bus.oIRQ_PEND);
      V_PIN:   return 64'(bus.oPIO_IN);
      default: return '1;
    endcase
  endfunction

  task automatic expectAt(input string tag, input int field, input int pin, input int delay,
                          input logic [63:0] exp);
    sbEntry_t e;
    e.tag   = tag;
    e.field = field;
    e.pin   = pin;
    e.exp   = exp;
    e.due   = cyc + delay;
    sbQ.push_back(e);
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge iCLK);
      #1;
    end
  endtask

  task automatic setMsel(input int pin, input int f);
    bus.iMSEL[pin*SEL_W +: SEL_W] = SEL_W'(f);
  endtask

  always @(negedge iCLK) begin
    for (int i = sbQ.size() - 1; i >= 0; i--) begin
      if (sbQ[i].due == cyc) begin
        checkVal(sbQ[i].tag, getField(sbQ[i].field, sbQ[i].pin), sbQ[i].exp);
        sbQ.delete(i);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N_PINS-1:0] rd, ro;

    iRESET           = 1'b1;
    bus.iPIO_OUT     = N_PINS'($urandom);
    bus.iPIO_DIR     = N_PINS'($urandom);
    bus.iMSEL        = (N_PINS*SEL_W)'({$urandom, $urandom});
    bus.iALT_OUT     = ALT_W'({$urandom, $urandom});
    bus.iPIN_IN      = N_PINS'($urandom);
    bus.iIRQ_RISE_EN = N_PINS'($urandom);
    bus.iIRQ_FALL_EN = N_PINS'($urandom);
    bus.iIRQ_CLR     = N_PINS'($urandom);
    for (int d = 1; d <= 3; d++) begin
      expectAt("rst_oe", V_OE, 0, d, 0);
      expectAt("rst_out", V_OUT, 0, d, 0);
      expectAt("rst_msel", V_MSEL, 0, d, 0);
      expectAt("rst_pend", V_PEND, 0, d, 0);
      expectAt("rst_irq", F_IRQ, 0, d, 0);
      expectAt("rst_pio", V_PIN, 0, d, 0);
    end
    tick(3);

    iRESET           = 1'b0;
    bus.iPIO_OUT     = '0;
    bus.iPIO_DIR     = '0;
    bus.iMSEL        = '0;
    bus.iALT_OUT     = '0;
    bus.iPIN_IN      = '0;
    bus.iIRQ_RISE_EN = '0;
    bus.iIRQ_FALL_EN = '0;
    bus.iIRQ_CLR     = '0;
    expectAt("irq_after_rst", F_IRQ, 0, 1, 0);
    expectAt("oe_after_rst", V_OE, 0, 1, 0);
    expectAt("pend_after_rst", V_PEND, 0, 1, 0);
    tick();

    for (int p = 0; p < 4; p++) begin
      rd = N_PINS'($urandom);
      ro = N_PINS'($urandom);
      bus.iPIO_DIR = rd;
      bus.iPIO_OUT = ro;
      expectAt("gpio_oe_vec", V_OE, 0, 1, 64'(rd));
      expectAt("gpio_out_vec", V_OUT, 0, 1, 64'(rd & ro));
      tick();
    end

    bus.iPIO_DIR    = '0;
    bus.iPIO_OUT    = '0;
    bus.iPIO_DIR[3] = 1'b1;
    bus.iPIO_OUT[3] = 1'b1;
    expectAt("gpio3_oe", F_OE, 3, 1, 1);
    expectAt("gpio3_out", F_OUT, 3, 1, 1);
    tick();
    bus.iPIO_DIR[3] = 1'b0;
    expectAt("gpio3_oe_off", F_OE, 3, 1, 0);
    expectAt("gpio3_out_off", F_OUT, 3, 1, 0);
    tick();

    bus.iALT_OUT[1*N_PINS + 5] = 1'b1;
    bus.iALT_OUT[9]            = 1'b1;
    bus.iALT_OUT[2*N_PINS + 9] = 1'b0;
    bus.iALT_OUT[11]           = 1'b1;
    bus.iPIO_DIR[5] = 1'b1;
    bus.iPIO_DIR[9] = 1'b1;
    bus.iPIO_OUT[9] = 1'b1;
    tick();

    setMsel(5, 2);
    expectAt("bbm5_oe_old", F_OE, 5, 1, 1);
    for (int d = 2; d <= BBM + 1; d++) begin
      expectAt("bbm5_oe_gap", F_OE, 5, d, 0);
      expectAt("bbm5_out_gap", F_OUT, 5, d, 0);
      expectAt("bbm5_msel_gap", F_MSEL, 5, d, 0);
    end
    expectAt("bbm5_oe_new", F_OE, 5, BBM + 2, 1);
    expectAt("bbm5_out_new", F_OUT, 5, BBM + 2, 1);
    expectAt("bbm5_msel_new", F_MSEL, 5, BBM + 2, 2);
    tick(BBM + 2);

    setMsel(9, 1);
    expectAt("rs9_oe_old", F_OE, 9, 1, 1);
    expectAt("rs9_out_old", F_OUT, 9, 1, 1);
    for (int d = 2; d <= 7; d++) expectAt("rs9_oe_gap", F_OE, 9, d, 0);
    expectAt("rs9_oe_new", F_OE, 9, 8, 1);
    expectAt("rs9_out_new", F_OUT, 9, 8, 0);
    expectAt("rs9_msel_new", F_MSEL, 9, 8, 3);
    tick(2);
    setMsel(9, 3);
    tick(6);

    bus.iIRQ_RISE_EN[7] = 1'b1;
    bus.iPIN_IN[7]      = 1'b1;
    expectAt("irq_pio_early", F_PIN, 7, 1, 0);
    expectAt("irq_pio_sync", F_PIN, 7, SYNC, 1);
    expectAt("irq_pend_early", F_PEND, 7, SYNC, 0);
    expectAt("irq_pend_set", F_PEND, 7, SYNC + 1, 1);
    expectAt("irq_out_early", F_IRQ, 0, SYNC + 1, 0);
    expectAt("irq_out_set", F_IRQ, 0, SYNC + 2, 1);
    tick(4);
    bus.iIRQ_CLR[7] = 1'b1;
    expectAt("irq_clr", F_PEND, 7, 1, 0);
    expectAt("irq_out_clr", F_IRQ, 0, 2, 0);
    tick();
    bus.iIRQ_CLR[7] = 1'b0;
    tick(2);
    bus.iPIN_IN[7] = 1'b0;
    expectAt("irq_fall_masked", F_PEND, 7, 3, 0);
    expectAt("irq_fall_masked", F_PEND, 7, 4, 0);
    tick(4);
    bus.iPIN_IN[7] = 1'b1;
    expectAt("irq_rise2", F_PEND, 7, 3, 1);
    tick(3);
    bus.iIRQ_FALL_EN[7] = 1'b1;
    bus.iPIN_IN[7]      = 1'b0;
    for (int d = 1; d <= 4; d++) expectAt("irq_set_wins", F_PEND, 7, d, 1);
    tick(2);
    bus.iIRQ_CLR[7] = 1'b1;
    tick();
    bus.iIRQ_CLR[7]     = 1'b0;
    bus.iIRQ_RISE_EN[7] = 1'b0;
    bus.iIRQ_FALL_EN[7] = 1'b0;
    expectAt("irq_hold_dis", F_PEND, 7, 1, 1);
    expectAt("irq_hold_dis", F_PEND, 7, 2, 1);
    expectAt("irq_out_hold", F_IRQ, 0, 1, 1);
    tick(2);
    bus.iIRQ_CLR[7] = 1'b1;
    expectAt("irq_clr2", F_PEND, 7, 1, 0);
    tick();
    bus.iIRQ_CLR[7] = 1'b0;
    bus.iPIN_IN[7]  = 1'b1;
    for (int d = 1; d <= 4; d++) expectAt("irq_rise_masked", F_PEND, 7, d, 0);
    tick(4);

    bus.iPIO_DIR[11] = 1'b1;
    bus.iPIO_OUT[11] = 1'b0;
    tick();
    setMsel(11, 1);
    expectAt("rbrk_oe_old", F_OE, 11, 1, 1);
    expectAt("rbrk_oe_gap", F_OE, 11, 2, 0);
    tick(2);
    iRESET       = 1'b1;
    bus.iMSEL    = '0;
    bus.iPIO_DIR = '0;
    bus.iPIO_OUT = '0;
    expectAt("rbrk_oe_vec", V_OE, 0, 1, 0);
    expectAt("rbrk_msel_vec", V_MSEL, 0, 1, 0);
    expectAt("rbrk_pend_vec", V_PEND, 0, 1, 0);
    expectAt("rbrk_irq", F_IRQ, 0, 1, 0);
    tick();
    iRESET = 1'b0;
    for (int d = 1; d <= 8; d++) begin
      expectAt("rbrk_oe_after", F_OE, 11, d, 0);
      expectAt("rbrk_msel_after", V_MSEL, 0, d, 0);
    end
    tick(9);

    checkVal("sb_drain", 64'(sbQ.size()), 0);
    $display("test done: total=%0d bad=%0d", nChecks, nBad);
    $finish;
  end
endmodule
